// File: rtl/fifo16_s1_s4_pkg.sv
// Shared widths, buffer occupancy encoding and level arithmetic for the
// bit-serial-in / nibble-out FIFO controller.
`timescale 1ns/1ps
package fifo16_s1_s4_pkg;

  localparam int unsigned WPTR_W   = 15;
  localparam int unsigned RPTR_W   = 13;
  localparam int unsigned ADDRA_W  = 14;
  localparam int unsigned ADDRB_W  = 12;
  localparam int unsigned RAM_BITS = 16384;
  localparam int unsigned NIB_W    = 4;

  localparam logic [WPTR_W-1:0] LEVEL_FULL = WPTR_W'(RAM_BITS);

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_TWO   = 2'd2
  } buf_state_e;

  // Read pointer counts nibbles, so scale it to bits before subtracting.
  function automatic logic [WPTR_W-1:0] bit_level(input logic [WPTR_W-1:0] wptr,
                                                  input logic [RPTR_W-1:0] rptr);
    return wptr - {rptr, 2'b00};
  endfunction

endpackage

// File: rtl/fifo16_out_buf2.sv
// Two-entry nibble FIFO that absorbs the RAM's registered read; head entry
// drives the consumer directly.
`timescale 1ns/1ps
module fifo16_out_buf2
  import fifo16_s1_s4_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             push,
  input  logic [NIB_W-1:0] push_data,
  input  logic             pop,
  output logic [NIB_W-1:0] head,
  output logic             valid,
  output logic [1:0]       count
);

  buf_state_e       state_q, state_d;
  logic [NIB_W-1:0] head_q, head_d;
  logic [NIB_W-1:0] tail_q, tail_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BUF_EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (clr) begin
      state_d = BUF_EMPTY;
    end else begin
      case (state_q)
        BUF_EMPTY: begin
          if (push) begin
            head_d  = push_data;
            state_d = BUF_ONE;
          end
        end
        BUF_ONE: begin
          case ({push, pop})
            2'b11: head_d = push_data;
            2'b10: begin
              tail_d  = push_data;
              state_d = BUF_TWO;
            end
            2'b01: state_d = BUF_EMPTY;
            default: ;
          endcase
        end
        BUF_TWO: begin
          // Parent never pushes into a full buffer unless it also pops.
          if (pop) begin
            head_d = tail_q;
            if (push) tail_d  = push_data;
            else      state_d = BUF_ONE;
          end
        end
        default: state_d = BUF_EMPTY;
      endcase
    end
  end

  assign head  = head_q;
  assign valid = (state_q != BUF_EMPTY);
  assign count = state_q;

endmodule

// File: rtl/fifo16_s1_s4_ctrl.sv
// Controller for a 16 Kbit dual-port RAM: 1-bit write port A fed by a serial
// producer, 4-bit read port B drained into a 2-entry output buffer.
`timescale 1ns/1ps
module fifo16_s1_s4_ctrl
  import fifo16_s1_s4_pkg::*;
#(
  parameter logic [15:0] AFULL_THRESH  = 16'd16000,
  parameter logic [15:0] AEMPTY_THRESH = 16'd4
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               FLUSH,
  input  logic               IN_BIT,
  input  logic               IN_VALID,
  output logic               IN_READY,
  output logic [NIB_W-1:0]   OUT_NIB,
  output logic               OUT_VALID,
  input  logic               OUT_READY,
  output logic [WPTR_W-1:0]  BIT_LEVEL,
  output logic               ALMOST_FULL,
  output logic               ALMOST_EMPTY,
  output logic [ADDRA_W-1:0] ADDRA,
  output logic               DIA,
  output logic               ENA,
  output logic               WEA,
  output logic               SSRA,
  output logic [ADDRB_W-1:0] ADDRB,
  output logic               ENB,
  output logic               WEB,
  output logic               SSRB,
  input  logic [NIB_W-1:0]   DOB
);

  logic [WPTR_W-1:0] wptr_q, wptr_d;
  logic [RPTR_W-1:0] rptr_q, rptr_d;
  logic              inflight_q, inflight_d;
  logic              alive_q, alive_d;

  logic [WPTR_W-1:0] level;
  logic              full;
  logic              wr_en;
  logic              rd_en;
  logic              pop;
  logic              buf_valid;
  logic [1:0]        buf_cnt;
  logic [2:0]        occ_next;

  assign level = bit_level(wptr_q, rptr_q);
  assign full  = (level == LEVEL_FULL);

  assign IN_READY = alive_q & ~full & ~FLUSH;
  assign wr_en    = IN_VALID & IN_READY;

  // Buffer slots still claimed after this cycle, counting a read in flight.
  assign pop      = buf_valid & OUT_READY;
  assign occ_next = 3'(buf_cnt) + 3'(inflight_q) - 3'(pop);
  assign rd_en    = ~FLUSH & (level >= WPTR_W'(NIB_W)) & (occ_next < 3'd2);

  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    inflight_d = rd_en;
    alive_d    = 1'b1;
    if (FLUSH) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (wr_en) wptr_d = wptr_q + 1'b1;
      if (rd_en) rptr_d = rptr_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      inflight_q <= 1'b0;
      alive_q    <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      inflight_q <= inflight_d;
      alive_q    <= alive_d;
    end
  end

  // FLUSH clears the buffer with priority, so a read returning that cycle is lost.
  fifo16_out_buf2 u_out_buf (
    .clk       (CLK),
    .rst_n     (RST_N),
    .clr       (FLUSH),
    .push      (inflight_q),
    .push_data (DOB),
    .pop       (pop),
    .head      (OUT_NIB),
    .valid     (buf_valid),
    .count     (buf_cnt)
  );

  assign OUT_VALID    = buf_valid;
  assign BIT_LEVEL    = level;
  assign ALMOST_FULL  = ({1'b0, level} >= AFULL_THRESH);
  assign ALMOST_EMPTY = ({1'b0, level} <  AEMPTY_THRESH);

  assign ENA   = wr_en;
  assign WEA   = wr_en;
  assign ADDRA = wptr_q[ADDRA_W-1:0];
  assign DIA   = wr_en & IN_BIT;
  assign SSRA  = 1'b0;

  assign ENB   = rd_en;
  assign ADDRB = rptr_q[ADDRB_W-1:0];
  assign WEB   = 1'b0;
  assign SSRB  = 1'b0;

endmodule

// File: tb/tb_fifo16_s1_s4_ctrl.sv
// Bench for fifo16_s1_s4_ctrl: RAM model on the port signals plus a bit-queue
// scoreboard describing the FIFO in terms of bits in and nibbles out.
`timescale 1ns/1ps
module tb_fifo16_s1_s4_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_bit;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  out_nib;
  logic        out_valid;
  logic        out_ready;
  logic [14:0] bit_level;
  logic        almost_full;
  logic        almost_empty;
  logic [13:0] addra;
  logic        dia, ena, wea, ssra;
  logic [11:0] addrb;
  logic        enb, web, ssrb;
  logic [3:0]  dob;

  always #5 clk = ~clk;

  fifo16_s1_s4_ctrl #(
    .AFULL_THRESH  (16'd16000),
    .AEMPTY_THRESH (16'd4)
  ) dut (
    .CLK          (clk),
    .RST_N        (rst_n),
    .FLUSH        (flush),
    .IN_BIT       (in_bit),
    .IN_VALID     (in_valid),
    .IN_READY     (in_ready),
    .OUT_NIB      (out_nib),
    .OUT_VALID    (out_valid),
    .OUT_READY    (out_ready),
    .BIT_LEVEL    (bit_level),
    .ALMOST_FULL  (almost_full),
    .ALMOST_EMPTY (almost_empty),
    .ADDRA        (addra),
    .DIA          (dia),
    .ENA          (ena),
    .WEA          (wea),
    .SSRA         (ssra),
    .ADDRB        (addrb),
    .ENB          (enb),
    .WEB          (web),
    .SSRB         (ssrb),
    .DOB          (dob)
  );

  // 16384x1 write / 4096x4 read RAM; nibble k holds bits 4k..4k+3, bit 0 lowest.
  logic mem [0:16383];
  always @(posedge clk) begin
    if (ena && wea) mem[addra] <= dia;
    if (enb) dob <= {mem[{addrb, 2'd3}], mem[{addrb, 2'd2}],
                     mem[{addrb, 2'd1}], mem[{addrb, 2'd0}]};
  end

  bit         bitq[$];
  logic [3:0] seen[$];
  int         tests = 0;
  int         fails = 0;
  int         cyc = 0;
  int         first_ov = -1;
  int         c4 = -1;
  int         peak = 0;
  int         npop = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Level once the pipeline has settled: whole nibbles fill the buffer first.
  function automatic int exp_level();
    int avail, nb;
    avail = bitq.size();
    nb = avail / 4;
    if (nb > 2) nb = 2;
    return avail - 4 * nb;
  endfunction

  task automatic cycle();
    logic [3:0] exp;
    @(negedge clk);
    cyc++;
    if (int'(bit_level) > peak) peak = int'(bit_level);
    if (out_valid && first_ov < 0) first_ov = cyc;
    if (in_valid && in_ready) bitq.push_back(in_bit);
    if (out_valid && out_ready) begin
      npop++;
      seen.push_back(out_nib);
      tests++;
      assert (bitq.size() >= 4) else begin
        fails++;
        $error("FAIL out_underflow: observed nibble %0h with only %0d bits queued", out_nib, bitq.size());
      end
      if (bitq.size() >= 4) begin
        exp = {bitq[3], bitq[2], bitq[1], bitq[0]};
        repeat (4) void'(bitq.pop_front());
        check("out_nib", 32'(out_nib), 32'(exp));
      end
    end
    if (flush) bitq.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},  32'(in_ready), 0);
    check({tag, "_out_valid"}, 32'(out_valid), 0);
    check({tag, "_level"},     32'(bit_level), 0);
    check({tag, "_afull"},     32'(almost_full), 0);
    check({tag, "_aempty"},    32'(almost_empty), 1);
    check({tag, "_ena_wea"},   32'({ena, wea}), 0);
    check({tag, "_enb"},       32'(enb), 0);
    check({tag, "_addra"},     32'(addra), 0);
    check({tag, "_addrb"},     32'(addrb), 0);
    check({tag, "_dia"},       32'(dia), 0);
  endtask

  initial begin
    logic [7:0] pat;
    int         p0;

    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
    in_valid = 1'b1; in_bit = 1'b1;
    #12;
    check_reset_outputs("rst");
    check("tied_zero", 32'({ssra, web, ssrb}), 0);
    in_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("ready_after_reset", 32'(in_ready), 1);

    // Known pattern: two nibbles D then 4, latency and level peak.
    pat = 8'b0100_1101;
    out_ready = 1'b1;
    peak = 0;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_bit = pat[i];
      cycle();
      if (i == 3) c4 = cyc;
    end
    in_valid = 1'b0;
    repeat (8) cycle();
    check("pat_count", 32'(seen.size()), 2);
    if (seen.size() >= 2) begin
      check("pat_nib0", 32'(seen[0]), 32'h0D);
      check("pat_nib1", 32'(seen[1]), 32'h04);
    end
    check("first_valid_latency", 32'(first_ov - c4), 3);
    check("pat_peak_level", 32'(peak), 4);
    check("pat_level_end", 32'(bit_level), 0);
    check("pat_aempty_end", 32'(almost_empty), 1);

    // Partial nibble stays hidden until completed.
    p0 = npop;
    in_valid = 1'b1;
    repeat (6) begin in_bit = 1'($urandom); cycle(); end
    in_valid = 1'b0;
    repeat (10) cycle();
    check("partial_pops", 32'(npop - p0), 1);
    check("partial_level", 32'(bit_level), 32'(exp_level()));
    check("partial_level2", 32'(bit_level), 2);
    check("partial_aempty", 32'(almost_empty), 1);
    in_valid = 1'b1;
    repeat (2) begin in_bit = 1'($urandom); cycle(); end
    in_valid = 1'b0;
    repeat (6) cycle();
    check("partial_complete_pops", 32'(npop - p0), 2);
    check("partial_complete_level", 32'(bit_level), 0);

    // FLUSH on the would-be issue cycle blocks the read.
    out_ready = 1'b0;
    in_valid = 1'b1;
    repeat (4) begin in_bit = 1'($urandom); cycle(); end
    in_valid = 1'b1;
    flush = 1'b1;
    #1;
    check("flushA_enb", 32'(enb), 0);
    check("flushA_in_ready", 32'(in_ready), 0);
    check("flushA_ena", 32'(ena), 0);
    cycle();
    flush = 1'b0; in_valid = 1'b0;
    repeat (4) cycle();
    check("flushA_out_valid", 32'(out_valid), 0);
    check("flushA_level", 32'(bit_level), 0);

    // FLUSH while the issued read returns: returning DOB is dropped.
    in_valid = 1'b1;
    repeat (4) begin in_bit = 1'($urandom); cycle(); end
    in_valid = 1'b0;
    check("flushB_issue", 32'(enb), 1);
    cycle();
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    check("flushB_out_valid", 32'(out_valid), 0);
    check("flushB_level", 32'(bit_level), 0);
    repeat (4) cycle();
    check("flushB_dropped", 32'(out_valid), 0);
    p0 = npop;
    out_ready = 1'b1;
    in_valid = 1'b1;
    repeat (12) begin in_bit = 1'($urandom); cycle(); end
    in_valid = 1'b0;
    repeat (8) cycle();
    check("flushB_after_pops", 32'(npop - p0), 3);

    // Fill with consumer stalled: threshold edge, then full.
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 20000 && bitq.size() < 16007; i++) begin
      in_bit = 1'($urandom);
      cycle();
    end
    in_valid = 1'b0;
    repeat (4) cycle();
    check("af_below_level", 32'(bit_level), 32'(exp_level()));
    check("af_below_level_abs", 32'(bit_level), 15999);
    check("af_below", 32'(almost_full), 0);
    check("af_below_aempty", 32'(almost_empty), 0);
    in_valid = 1'b1; in_bit = 1'($urandom);
    cycle();
    in_valid = 1'b0;
    repeat (4) cycle();
    check("af_at_level", 32'(bit_level), 16000);
    check("af_at", 32'(almost_full), 1);
    in_valid = 1'b1;
    repeat (420) begin in_bit = 1'($urandom); cycle(); end
    check("full_accepted", 32'(bitq.size()), 16392);
    check("full_level", 32'(bit_level), 32'(exp_level()));
    check("full_level_abs", 32'(bit_level), 16384);
    check("full_in_ready", 32'(in_ready), 0);
    check("full_ena", 32'(ena), 0);
    check("full_afull", 32'(almost_full), 1);

    // Continuous stream from full across both address wraps.
    out_ready = 1'b1;
    repeat (40000) begin in_bit = 1'($urandom); cycle(); end
    in_valid = 1'b0;
    repeat (60) cycle();
    check("stream_residual", 32'(bit_level), 32'(bitq.size()));
    check("stream_out_valid", 32'(out_valid), 0);

    // Random producer/consumer stalls.
    repeat (3000) begin
      in_valid = 1'($urandom);
      in_bit = 1'($urandom);
      out_ready = 1'($urandom);
      cycle();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (60) cycle();
    check("rand_residual", 32'(bit_level), 32'(bitq.size()));

    // Asynchronous reset between edges, mid-stream.
    in_valid = 1'b1;
    repeat (30) begin in_bit = 1'($urandom); out_ready = 1'($urandom); cycle(); end
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async");
    bitq.delete();
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("async_ready", 32'(in_ready), 1);
    p0 = npop;
    out_ready = 1'b1;
    repeat (40) begin in_bit = 1'($urandom); cycle(); end
    in_valid = 1'b0;
    repeat (10) cycle();
    check("async_resume_pops", 32'(npop - p0), 10);
    check("async_resume_level", 32'(bit_level), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
